// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and default configuration for the writeback
//                buffer (wb_fifo, wb_buffer).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int C_DATA_WIDTH   = 32;
    localparam int C_SIZE_REGFILE = 3;
    localparam int C_DEPTH        = 4;
    localparam int C_ZERO_REG     = 1;

    // One queued register-file write in the default configuration.
    typedef struct packed {
        logic [C_SIZE_REGFILE-1:0] dest;
        logic [C_DATA_WIDTH-1:0]   data;
    } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : 2-write / 1-read FIFO of register-file writes. Port 0 is
//                enqueued ahead of port 1 when both push in the same cycle.
//                Per-entry valid bits and destinations are exported so the
//                parent can build a pending-write mask.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push0/1       - enqueue strobes, i_dest*/i_data* payload
//                i_pop           - dequeue head (only when o_count != 0)
//                o_head_dest/data- current head entry
//                o_count         - occupancy
//                o_valid         - per-slot valid bits
//                o_dest_vec      - per-slot destinations, slot i at [i*SR +: SR]
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = C_DATA_WIDTH,
    parameter int SIZE_REGFILE = C_SIZE_REGFILE,
    parameter int DEPTH        = C_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push0,
    input  logic [SIZE_REGFILE-1:0]       i_dest0,
    input  logic [DATA_WIDTH-1:0]         i_data0,
    input  logic                          i_push1,
    input  logic [SIZE_REGFILE-1:0]       i_dest1,
    input  logic [DATA_WIDTH-1:0]         i_data1,
    input  logic                          i_pop,
    output logic [SIZE_REGFILE-1:0]       o_head_dest,
    output logic [DATA_WIDTH-1:0]         o_head_data,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [DEPTH-1:0]              o_valid,
    output logic [DEPTH*SIZE_REGFILE-1:0] o_dest_vec
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SIZE_REGFILE-1:0] r_dest [DEPTH];
    logic [DATA_WIDTH-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]        r_valid;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    logic [PTR_W-1:0]        w_slot1;
    logic [DEPTH-1:0]        w_valid_next;
    logic [CNT_W-1:0]        w_count_next;

    // Port 1 lands behind port 0 when both push; DEPTH is a power of two so
    // pointer arithmetic wraps naturally.
    assign w_slot1      = r_wr_ptr + PTR_W'(i_push0);
    assign w_count_next = r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);

    // Payload storage needs no reset: slot validity is tracked separately.
    always_ff @(posedge clk) begin
        if (i_push0) begin
            r_dest[r_wr_ptr] <= i_dest0;
            r_data[r_wr_ptr] <= i_data0;
        end
        if (i_push1) begin
            r_dest[w_slot1] <= i_dest1;
            r_data[w_slot1] <= i_data1;
        end
    end

    // The parent only pushes with at least two free slots, so pushed slots
    // never collide with the popped head slot.
    always_comb begin
        w_valid_next = r_valid;
        if (i_pop) begin
            w_valid_next[r_rd_ptr] = 1'b0;
        end
        if (i_push0) begin
            w_valid_next[r_wr_ptr] = 1'b1;
        end
        if (i_push1) begin
            w_valid_next[w_slot1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push0) + PTR_W'(i_push1);
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_valid <= w_valid_next;
        end
    end

    assign o_head_dest = r_dest[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_count     = r_count;
    assign o_valid     = r_valid;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dest_vec
            assign o_dest_vec[gi*SIZE_REGFILE +: SIZE_REGFILE] = r_dest[gi];
        end
    endgenerate

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_buffer
//  Description : Writeback buffer in front of the register-file write port.
//                Accepts ALU and load results, queues them in arrival order
//                (ALU ahead of load within a cycle), drains one per cycle into
//                a registered write port and exposes a pending-write mask.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                alu_valid/ready/dest/data   - ALU result handshake
//                ld_valid/ready/dest/data    - load result handshake
//                rg_wrt_en/dest/data         - registered register-file write
//                busy_mask                   - registers with a pending write
//                count                       - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_buffer
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = C_DATA_WIDTH,
    parameter int SIZE_REGFILE = C_SIZE_REGFILE,
    parameter int DEPTH        = C_DEPTH,
    parameter int ZERO_REG     = C_ZERO_REG
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [SIZE_REGFILE-1:0]      alu_dest,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [SIZE_REGFILE-1:0]      ld_dest,
    input  logic [DATA_WIDTH-1:0]        ld_data,
    output logic                         rg_wrt_en,
    output logic [SIZE_REGFILE-1:0]      rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]        rg_wrt_data,
    output logic [2**SIZE_REGFILE-1:0]   busy_mask,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int                CNT_W       = $clog2(DEPTH) + 1;
    localparam int                NREG        = 2**SIZE_REGFILE;
    localparam logic [CNT_W-1:0]  C_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  C_MIN_FREE  = CNT_W'(2);

    logic                          w_ready;
    logic                          w_push_alu;
    logic                          w_push_ld;
    logic                          w_pop;
    logic                          w_discard;
    logic [SIZE_REGFILE-1:0]       w_head_dest;
    logic [DATA_WIDTH-1:0]         w_head_data;
    logic [CNT_W-1:0]              w_count;
    logic [DEPTH-1:0]              w_valid;
    logic [DEPTH*SIZE_REGFILE-1:0] w_dest_vec;
    logic [NREG-1:0]               w_busy;

    logic                          r_wrt_en;
    logic [SIZE_REGFILE-1:0]       r_wrt_dest;
    logic [DATA_WIDTH-1:0]         r_wrt_data;

    // Ready looks only at registered occupancy: two free slots guarantee a
    // dual push fits regardless of whether a pop happens this cycle.
    assign w_ready    = (C_DEPTH_CNT - w_count) >= C_MIN_FREE;
    assign w_push_alu = alu_valid && w_ready;
    assign w_push_ld  = ld_valid && w_ready;
    assign w_pop      = (w_count != '0);
    assign w_discard  = (ZERO_REG != 0) && (w_head_dest == '0);

    wb_fifo #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SIZE_REGFILE (SIZE_REGFILE),
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push0     (w_push_alu),
        .i_dest0     (alu_dest),
        .i_data0     (alu_data),
        .i_push1     (w_push_ld),
        .i_dest1     (ld_dest),
        .i_data1     (ld_data),
        .i_pop       (w_pop),
        .o_head_dest (w_head_dest),
        .o_head_data (w_head_data),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_dest_vec  (w_dest_vec)
    );

    // A discarded register-0 entry still occupies the write slot: dest/data
    // load as usual, only the enable is suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrt_en   <= 1'b0;
            r_wrt_dest <= '0;
            r_wrt_data <= '0;
        end else if (w_pop) begin
            r_wrt_en   <= !w_discard;
            r_wrt_dest <= w_head_dest;
            r_wrt_data <= w_head_data;
        end else begin
            r_wrt_en   <= 1'b0;
        end
    end

    // Pending writes are everything still queued plus the write being
    // presented to the register file this cycle.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) begin
                w_busy[w_dest_vec[i*SIZE_REGFILE +: SIZE_REGFILE]] = 1'b1;
            end
        end
        if (r_wrt_en) begin
            w_busy[r_wrt_dest] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy[0] = 1'b0;
        end
    end

    assign alu_ready   = w_ready;
    assign ld_ready    = w_ready;
    assign rg_wrt_en   = r_wrt_en;
    assign rg_wrt_dest = r_wrt_dest;
    assign rg_wrt_data = r_wrt_data;
    assign busy_mask   = w_busy;
    assign count       = w_count;

endmodule : wb_buffer
`default_nettype wire

// File: tb/tb_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_buffer
//  Description : Directed self-checking bench for wb_buffer (DEPTH=4,
//                SIZE_REGFILE=3, DATA_WIDTH=32, ZERO_REG=1).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_buffer;

    localparam int DW    = 32;
    localparam int SR    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [SR-1:0] alu_dest = '0;
    logic [DW-1:0] alu_data = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [SR-1:0] ld_dest = '0;
    logic [DW-1:0] ld_data = '0;
    logic          rg_wrt_en;
    logic [SR-1:0] rg_wrt_dest;
    logic [DW-1:0] rg_wrt_data;
    logic [7:0]    busy_mask;
    logic [2:0]    count;

    int n_checks = 0;
    int n_errors = 0;

    wb_buffer #(
        .DATA_WIDTH   (DW),
        .SIZE_REGFILE (SR),
        .DEPTH        (DEPTH),
        .ZERO_REG     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_dest    (alu_dest),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_dest     (ld_dest),
        .ld_data     (ld_data),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_dest (rg_wrt_dest),
        .rg_wrt_data (rg_wrt_data),
        .busy_mask   (busy_mask),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (rg_wrt_en !== 1'b0) begin n_errors++; $display("FAIL reset_en: got %0b expected 0", rg_wrt_en); end
        n_checks++; if (rg_wrt_dest !== 3'd0 || rg_wrt_data !== 32'd0) begin n_errors++; $display("FAIL reset_dest_data: got %0d/%0h expected 0/0", rg_wrt_dest, rg_wrt_data); end
        n_checks++; if (busy_mask !== 8'h00) begin n_errors++; $display("FAIL reset_busy: got %0h expected 00", busy_mask); end
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %0b%0b expected 11", alu_ready, ld_ready); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        alu_valid = 1'b0;
        n_checks++; if (count !== 3'd1) begin n_errors++; $display("FAIL single_count: got %0d expected 1", count); end
        n_checks++; if (busy_mask !== 8'h20 || rg_wrt_en !== 1'b0) begin n_errors++; $display("FAIL single_c2: got busy %0h en %0b expected 20/0", busy_mask, rg_wrt_en); end
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 3'd5 || rg_wrt_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_write: got %0b/%0d/%0h expected 1/5/deadbeef", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        n_checks++; if (busy_mask !== 8'h20) begin n_errors++; $display("FAIL single_busy_c3: got %0h expected 20", busy_mask); end
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b0 || busy_mask !== 8'h00) begin n_errors++; $display("FAIL single_c4: got en %0b busy %0h expected 0/00", rg_wrt_en, busy_mask); end
    endtask

    task automatic test_dual_push();
        alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 32'h11;
        ld_valid  = 1'b1; ld_dest  = 3'd1; ld_data  = 32'h22;
        @(negedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0;
        n_checks++; if (count !== 3'd2 || busy_mask !== 8'h02) begin n_errors++; $display("FAIL dual_queued: got count %0d busy %0h expected 2/02", count, busy_mask); end
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_data !== 32'h11 || busy_mask[1] !== 1'b1) begin n_errors++; $display("FAIL dual_first: got %0b/%0h busy %0h expected 1/11 busy bit1", rg_wrt_en, rg_wrt_data, busy_mask); end
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_data !== 32'h22 || busy_mask[1] !== 1'b1) begin n_errors++; $display("FAIL dual_second: got %0b/%0h busy %0h expected 1/22 busy bit1", rg_wrt_en, rg_wrt_data, busy_mask); end
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b0 || busy_mask !== 8'h00) begin n_errors++; $display("FAIL dual_done: got en %0b busy %0h expected 0/00", rg_wrt_en, busy_mask); end
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 32'hA4;
        @(negedge clk);
        alu_dest = 3'd5; alu_data = 32'hA5;
        n_checks++; if (count !== 3'd1) begin n_errors++; $display("FAIL b2b_count1: got %0d expected 1", count); end
        @(negedge clk);
        alu_dest = 3'd6; alu_data = 32'hA6;
        n_checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 3'd4 || rg_wrt_data !== 32'hA4) begin n_errors++; $display("FAIL b2b_w0: got %0b/%0d/%0h expected 1/4/a4", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        n_checks++; if (count !== 3'd1 || busy_mask !== 8'h30) begin n_errors++; $display("FAIL b2b_state: got count %0d busy %0h expected 1/30", count, busy_mask); end
        @(negedge clk);
        alu_valid = 1'b0;
        n_checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 3'd5 || rg_wrt_data !== 32'hA5) begin n_errors++; $display("FAIL b2b_w1: got %0b/%0d/%0h expected 1/5/a5", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 3'd6 || rg_wrt_data !== 32'hA6) begin n_errors++; $display("FAIL b2b_w2: got %0b/%0d/%0h expected 1/6/a6", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b0 || count !== 3'd0) begin n_errors++; $display("FAIL b2b_idle: got en %0b count %0d expected 0/0", rg_wrt_en, count); end
    endtask

    // Both sources offer every cycle; a queue of accepted entries predicts
    // the exact retire order and the occupancy-based readiness.
    task automatic test_fill();
        logic [SR-1:0] mq_dest[$];
        logic [DW-1:0] mq_data[$];
        logic          exp_en;
        logic [SR-1:0] exp_dest;
        logic [DW-1:0] exp_data;
        logic          rdy;
        int            seq, accepted, written;
        exp_en = 1'b0; exp_dest = '0; exp_data = '0; seq = 0; accepted = 0; written = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            rdy = ((DEPTH - mq_dest.size()) >= 2);
            n_checks++; if (count !== 3'(mq_dest.size())) begin n_errors++; $display("FAIL fill_count c%0d: got %0d expected %0d", cyc, count, mq_dest.size()); end
            n_checks++; if (alu_ready !== rdy || ld_ready !== rdy) begin n_errors++; $display("FAIL fill_ready c%0d: got %0b%0b expected %0b", cyc, alu_ready, ld_ready, rdy); end
            n_checks++; if (rg_wrt_en !== exp_en) begin n_errors++; $display("FAIL fill_en c%0d: got %0b expected %0b", cyc, rg_wrt_en, exp_en); end
            if (exp_en) begin
                written++;
                n_checks++; if (rg_wrt_dest !== exp_dest || rg_wrt_data !== exp_data) begin n_errors++; $display("FAIL fill_write c%0d: got %0d/%0h expected %0d/%0h", cyc, rg_wrt_dest, rg_wrt_data, exp_dest, exp_data); end
            end
            if (cyc < 14) begin
                alu_valid = 1'b1; alu_dest = 3'(1 + seq % 7);       alu_data = 32'(32'hA000 + seq);
                ld_valid  = 1'b1; ld_dest  = 3'(1 + (seq + 1) % 7); ld_data  = 32'(32'hA000 + seq + 1);
            end else begin
                alu_valid = 1'b0; ld_valid = 1'b0;
            end
            if (mq_dest.size() > 0) begin
                exp_en = 1'b1; exp_dest = mq_dest.pop_front(); exp_data = mq_data.pop_front();
            end else begin
                exp_en = 1'b0;
            end
            if (cyc < 14 && rdy) begin
                mq_dest.push_back(alu_dest); mq_data.push_back(alu_data);
                mq_dest.push_back(ld_dest);  mq_data.push_back(ld_data);
                seq += 2; accepted += 2;
            end
            @(negedge clk);
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        n_checks++; if (written !== accepted) begin n_errors++; $display("FAIL fill_total: got %0d writes expected %0d", written, accepted); end
    endtask

    task automatic test_zero_reg();
        alu_valid = 1'b1; alu_dest = 3'd0; alu_data = 32'hAA;
        @(negedge clk);
        alu_dest = 3'd2; alu_data = 32'hBB;
        n_checks++; if (busy_mask !== 8'h00 || count !== 3'd1) begin n_errors++; $display("FAIL zero_queued: got busy %0h count %0d expected 00/1", busy_mask, count); end
        @(negedge clk);
        alu_valid = 1'b0;
        n_checks++; if (rg_wrt_en !== 1'b0 || rg_wrt_dest !== 3'd0 || rg_wrt_data !== 32'hAA) begin n_errors++; $display("FAIL zero_discard: got %0b/%0d/%0h expected 0/0/aa", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        n_checks++; if (busy_mask !== 8'h04) begin n_errors++; $display("FAIL zero_busy: got %0h expected 04", busy_mask); end
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 3'd2 || rg_wrt_data !== 32'hBB) begin n_errors++; $display("FAIL zero_next: got %0b/%0d/%0h expected 1/2/bb", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 32'h31;
        ld_valid  = 1'b1; ld_dest  = 3'd4; ld_data  = 32'h41;
        @(negedge clk);
        alu_dest = 3'd5; alu_data = 32'h51; ld_dest = 3'd6; ld_data = 32'h61;
        @(negedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0;
        n_checks++; if (count !== 3'd3 || alu_ready !== 1'b0 || ld_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_full: got count %0d ready %0b%0b expected 3/00", count, alu_ready, ld_ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (rg_wrt_en !== 1'b0 || count !== 3'd0 || busy_mask !== 8'h00) begin n_errors++; $display("FAIL rstmid_clear: got en %0b count %0d busy %0h expected 0/0/00", rg_wrt_en, count, busy_mask); end
        n_checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready: got %0b%0b expected 11", alu_ready, ld_ready); end
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b0 || count !== 3'd0) begin n_errors++; $display("FAIL rstmid_after: got en %0b count %0d expected 0/0", rg_wrt_en, count); end
    endtask

    task automatic test_idle_hold();
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 32'h5A;
        @(negedge clk);
        alu_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 3'd3 || rg_wrt_data !== 32'h5A) begin n_errors++; $display("FAIL hold_write: got %0b/%0d/%0h expected 1/3/5a", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (rg_wrt_en !== 1'b0 || rg_wrt_dest !== 3'd3 || rg_wrt_data !== 32'h5A) begin n_errors++; $display("FAIL hold_idle%0d: got %0b/%0d/%0h expected 0/3/5a", k, rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_alu();
        test_dual_push();
        test_back_to_back();
        test_fill();
        test_zero_reg();
        test_reset_mid();
        test_idle_hold();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wb_buffer
`default_nettype wire
